// File: rtl/sme_stream_loader.sv
// Stream loader for the string-matching engine: buffers framed string/pattern
// records from a valid/ready byte stream and replays them as isstring/ispattern bursts.
module sme_stream_loader #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       err_ovf,
    output logic       err_nostr,
    output logic       err_timeout
);

    localparam int SA = $clog2(STR_MAX);
    localparam int PA = $clog2(PAT_MAX);
    localparam int SW = $clog2(STR_MAX + 1);
    localparam int PW = $clog2(PAT_MAX + 1);
    localparam logic [6:0] TO_LAST = 7'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SEND_STR = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_SEND_PAT = 3'd4;
    localparam logic [2:0] S_WAIT     = 3'd5;

    logic [2:0]    state, state_next;
    logic          rec_type;
    logic [SW-1:0] len;
    logic          ovf_seen;
    logic [SW-1:0] str_len;
    logic [PW-1:0] pat_len;
    logic          str_pend;
    logic          str_loaded;
    logic [SW-1:0] rd_idx;
    logic [6:0]    wait_cnt;
    logic [7:0]    str_buf [STR_MAX];
    logic [7:0]    pat_buf [PAT_MAX];

    logic          accept, cur_type, room, rec_end;
    logic          end_str, end_nostr, end_pat;
    logic          str_done, pat_done, timeout_hit;
    logic [SW-1:0] len_cur, len_next, cap, rd_sel;
    logic [7:0]    chardata_next;

    // The first beat of a record is seen in IDLE, so its type and index come
    // straight from the inputs rather than from the latched record state.
    assign accept      = in_valid & in_ready;
    assign cur_type    = (state == S_IDLE) ? in_type : rec_type;
    assign len_cur     = (state == S_IDLE) ? '0 : len;
    assign cap         = cur_type ? SW'(PAT_MAX) : SW'(STR_MAX);
    assign room        = (len_cur < cap);
    assign len_next    = room ? len_cur + SW'(1) : len_cur;
    assign rec_end     = accept & in_last;
    assign end_str     = rec_end & ~cur_type;
    assign end_nostr   = rec_end & cur_type & ~str_loaded;
    assign end_pat     = rec_end & cur_type & str_loaded;
    assign str_done    = (rd_idx == str_len);
    assign pat_done    = (rd_idx == SW'(pat_len));
    assign timeout_hit = (wait_cnt == TO_LAST);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (!in_last)     state_next = S_LOAD;
                    else if (end_pat) state_next = str_pend ? S_SEND_STR : S_SEND_PAT;
                    else              state_next = S_IDLE;
                end
            end
            S_SEND_STR: if (str_done) state_next = S_GAP;
            S_GAP:      state_next = S_SEND_PAT;
            S_SEND_PAT: if (pat_done) state_next = S_WAIT;
            S_WAIT:     if (sme_valid || timeout_hit) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Burst read index restarts at 0 whenever a send state is freshly entered.
    always_comb begin
        rd_sel        = (state == state_next) ? rd_idx : '0;
        chardata_next = 8'h00;
        if (state_next == S_SEND_STR) begin
            chardata_next = str_buf[rd_sel[SA-1:0]];
        end else if (state_next == S_SEND_PAT) begin
            // A one-byte pattern goes straight from IDLE; its byte is being written this edge.
            chardata_next = (state == S_IDLE) ? in_data : pat_buf[rd_sel[PA-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            rec_type      <= 1'b0;
            len           <= '0;
            ovf_seen      <= 1'b0;
            str_len       <= '0;
            pat_len       <= '0;
            str_pend      <= 1'b0;
            str_loaded    <= 1'b0;
            rd_idx        <= '0;
            wait_cnt      <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            sme_chardata  <= 8'h00;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            err_ovf       <= 1'b0;
            err_nostr     <= 1'b0;
            err_timeout   <= 1'b0;
            // NOTE: the record buffers are reset on purpose; a reset must leave no stale record behind.
            for (int i = 0; i < STR_MAX; i++) str_buf[i] <= 8'h00;
            for (int i = 0; i < PAT_MAX; i++) pat_buf[i] <= 8'h00;
        end else begin
            state         <= state_next;
            busy          <= (state_next != S_IDLE);
            in_ready      <= (state_next == S_IDLE) || (state_next == S_LOAD);
            sme_isstring  <= (state_next == S_SEND_STR);
            sme_ispattern <= (state_next == S_SEND_PAT);
            sme_chardata  <= chardata_next;
            rd_idx        <= rd_sel + SW'(1);
            wait_cnt      <= (state == S_WAIT) ? wait_cnt + 7'd1 : 7'd0;
            err_ovf       <= accept & ~room & ~ovf_seen;
            err_nostr     <= end_nostr;
            err_timeout   <= (state == S_WAIT) & ~sme_valid & timeout_hit;

            if (accept) begin
                rec_type <= cur_type;
                len      <= len_next;
                ovf_seen <= (state == S_LOAD) & (ovf_seen | ~room);
                if (room) begin
                    if (cur_type) pat_buf[len_cur[PA-1:0]] <= in_data;
                    else          str_buf[len_cur[SA-1:0]] <= in_data;
                end
            end

            if (end_str) begin
                str_len    <= len_next;
                str_pend   <= 1'b1;
                str_loaded <= 1'b1;
            end
            if (end_pat) begin
                pat_len  <= len_next[PW-1:0];
                str_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sme_stream_loader.sv
// Directed bench for sme_stream_loader: record loading, burst replay, pacing,
// overflow, missing-string, timeout and mid-burst reset behaviour.
module tb_sme_stream_loader;

    localparam int TIMEOUT = 63;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_type;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid;
    logic       busy;
    logic       err_ovf;
    logic       err_nostr;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    sme_stream_loader #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_type      (in_type),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sme_chardata (sme_chardata),
        .sme_isstring (sme_isstring),
        .sme_ispattern(sme_ispattern),
        .sme_valid    (sme_valid),
        .busy         (busy),
        .err_ovf      (err_ovf),
        .err_nostr    (err_nostr),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one beat at a negedge; returns at the negedge after the handshake edge.
    task automatic send_beat(input logic [7:0] d, input logic t, input logic l);
        int guard = 0;
        in_data  = d;
        in_type  = t;
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("handshake_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_record(input string s, input logic t);
        for (int i = 0; i < s.len(); i++) send_beat(s[i], t, i == s.len() - 1);
    endtask

    // Expect a burst of consecutive strobe cycles carrying the bytes of s.
    task automatic check_burst(input string tag, input logic pat, input string s);
        for (int i = 0; i < s.len(); i++) begin
            check({tag, "_strobes"}, {30'd0, sme_isstring, sme_ispattern}, pat ? 32'd1 : 32'd2);
            check({tag, "_data"}, {24'd0, sme_chardata}, {24'd0, s[i]});
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_quiet"}, {22'd0, sme_isstring, sme_ispattern, sme_chardata}, 32'd0);
    endtask

    task automatic pulse_sme_valid();
        sme_valid = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
    endtask

    initial begin
        int ovf_count;
        int ovf_beat;
        int to_cycle;

        reset     = 1'b0;
        in_data   = 8'h00;
        in_type   = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        sme_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {29'd0, err_ovf, err_nostr, err_timeout}, 32'd0);
        check_quiet("rst");
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Pattern with no string loaded is dropped with one err_nostr pulse.
        send_beat("x", 1'b1, 1'b1);
        check("nostr_pulse", {31'd0, err_nostr}, 32'd1);
        check("nostr_ready", {31'd0, in_ready}, 32'd1);
        check("nostr_busy", {31'd0, busy}, 32'd0);
        check_quiet("nostr");
        @(negedge clk);
        check("nostr_one_cycle", {31'd0, err_nostr}, 32'd0);
        check_quiet("nostr_after");

        // String "abcd": in_type toggled after the first beat must be ignored.
        send_beat("a", 1'b0, 1'b0);
        send_beat("b", 1'b1, 1'b0);
        send_beat("c", 1'b1, 1'b0);
        send_beat("d", 1'b1, 1'b1);
        check("str_loaded_idle", {31'd0, busy}, 32'd0);
        check_quiet("str_loaded");
        send_record("bc", 1'b1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_low", {31'd0, in_ready}, 32'd0);
        check_burst("t1_str", 1'b0, "abcd");
        check_quiet("t1_gap");
        @(negedge clk);
        check_burst("t1_pat", 1'b1, "bc");
        check_quiet("t1_wait");
        check("t1_wait_busy", {31'd0, busy}, 32'd1);
        pulse_sme_valid();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_ready", {31'd0, in_ready}, 32'd1);
        check("t1_no_timeout", {31'd0, err_timeout}, 32'd0);

        // Second pattern reuses the string without resending it.
        send_record("^a", 1'b1);
        check_burst("t2_pat", 1'b1, "^a");
        check_quiet("t2_wait");
        pulse_sme_valid();
        check("t2_idle_busy", {31'd0, busy}, 32'd0);

        // 35-byte string: truncated to 32 with a single err_ovf pulse on beat 32.
        ovf_count = 0;
        ovf_beat  = -1;
        for (int i = 0; i < 35; i++) begin
            send_beat(8'h40 + 8'(i), 1'b0, i == 34);
            if (err_ovf === 1'b1) begin
                ovf_count++;
                if (ovf_beat < 0) ovf_beat = i;
            end
        end
        check("ovf_count", ovf_count, 32'd1);
        check("ovf_beat", ovf_beat, 32'd32);
        send_record("pq", 1'b1);
        for (int i = 0; i < 32; i++) begin
            check("t4_str_strobes", {30'd0, sme_isstring, sme_ispattern}, 32'd2);
            check("t4_str_data", {24'd0, sme_chardata}, 32'h40 + i);
            @(negedge clk);
        end
        check_quiet("t4_gap");
        @(negedge clk);
        check_burst("t4_pat", 1'b1, "pq");

        // No sme_valid: err_timeout must appear TIMEOUT cycles after WAIT entry.
        to_cycle = -1;
        for (int k = 0; k < 100 && to_cycle < 0; k++) begin
            if (err_timeout === 1'b1) to_cycle = k;
            else @(negedge clk);
        end
        check("t5_timeout_cycle", to_cycle, TIMEOUT);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("t5_timeout_one_cycle", {31'd0, err_timeout}, 32'd0);

        // Reset on the 3rd isstring cycle drops strobes at once and forgets the string.
        send_record("wxyz", 1'b0);
        send_record("q", 1'b1);
        check_burst("t6_str", 1'b0, "wx");
        check("t6_third", {30'd0, sme_isstring, sme_ispattern}, 32'd2);
        reset = 1'b1;
        #1;
        check_quiet("t6_rst");
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rel_ready", {31'd0, in_ready}, 32'd1);
        send_beat("z", 1'b1, 1'b1);
        check("t6_nostr", {31'd0, err_nostr}, 32'd1);
        check_quiet("t6_nostr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
